outpkt_arbiter: RTL and testbench

- Shares the single 16-bit output FIFO write port among N_REQ result sources (e.g. several cores or comparators) on the output-FIFO write clock.
- Packet-atomic round-robin: once a source is granted, all of its words up to and including the word marked last go out uninterrupted.
- Presents the output FIFO with the usual dout/wr_en/full interface and reports packet count and error status for VCR readout.

---
 rtl/outpkt_arbiter_pkg.sv | 22 ++
 rtl/outpkt_arbiter_rr_select.sv | 39 +++
 rtl/outpkt_arbiter.sv | 166 ++++++++++++++++
 tb/tb_outpkt_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/outpkt_arbiter_pkg.sv
// outpkt_arbiter_pkg
// Shared definitions for the output-packet arbiter and its round-robin picker:
// FSM state encoding, data / packet-count / grant-index widths and the width
// of the optional mid-packet stall counter.
package outpkt_arbiter_pkg;

    // IDLE: arbitrating between requesters, XFER: moving one granted packet
    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    localparam int DATA_W      = 16;
    localparam int PKT_COUNT_W = 16;

    // Sized for the largest supported requester count (8)
    localparam int GRANT_ID_W  = 3;

    // Stall counter width used when the timeout feature is compiled in
    localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/outpkt_arbiter_rr_select.sv
// rr_select
// Combinational circular priority picker. Starting just after ptr and
// wrapping at N-1, it returns the first index whose valid bit is set.
// Ports:
//   valid : per-requester valid vector
//   ptr   : index of the last winner (search starts at ptr+1)
//   idx   : selected index (0 when nothing is valid)
//   any   : at least one valid bit is set
module rr_select
    import outpkt_arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]            valid,
    input  logic [GRANT_ID_W-1:0]   ptr,
    output logic [GRANT_ID_W-1:0]   idx,
    output logic                    any
);

    logic [GRANT_ID_W-1:0] cand;

    // Walk the ring one position at a time from ptr+1; the first valid
    // candidate encountered wins, so ptr itself is considered last.
    always_comb begin
        idx  = '0;
        any  = 1'b0;
        cand = ptr;
        for (int k = 0; k < N; k++) begin
            cand = (cand == GRANT_ID_W'(N - 1)) ? '0 : cand + 1'b1;
            for (int j = 0; j < N; j++) begin
                if (!any && (cand == GRANT_ID_W'(j)) && valid[j]) begin
                    idx = cand;
                    any = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/outpkt_arbiter.sv
// outpkt_arbiter
// Shares the 16-bit output FIFO write port among N_REQ FWFT result sources
// with packet-atomic round-robin arbitration. Once granted, a requester keeps
// the port until its word flagged last has been written.
// Optional feature macro: OUTPKT_ARB_TIMEOUT_EN (mid-packet stall timeout that
// sets the sticky err flag and truncates the packet).
// Ports:
//   CLK, RST   : write-side clock, asynchronous active-high reset
//   req_valid  : requester i has a word available
//   req_data   : requester i word at [16*i+15:16*i]
//   req_last   : requester i current word ends its packet
//   req_rd_en  : pop strobe back to the granted requester
//   dout       : word to the output FIFO (0 when not writing)
//   wr_en      : output FIFO write strobe
//   full       : output FIFO full
//   grant_id   : current / last granted requester
//   busy       : packet transfer in progress
//   pkt_count  : packets forwarded (wraps)
//   err        : sticky timeout error
module outpkt_arbiter
    import outpkt_arbiter_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [DATA_W*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          req_rd_en,
    output logic [DATA_W-1:0]         dout,
    output logic                      wr_en,
    input  logic                      full,
    output logic [GRANT_ID_W-1:0]     grant_id,
    output logic                      busy,
    output logic [PKT_COUNT_W-1:0]    pkt_count,
    output logic                      err
);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("outpkt_arbiter: N_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    arb_state_t              state;
    arb_state_t              state_next;
    logic [GRANT_ID_W-1:0]   rr_ptr;
    logic [GRANT_ID_W-1:0]   sel_idx;
    logic                    sel_any;
    logic                    g_valid;
    logic                    g_last;
    logic [DATA_W-1:0]       g_data;
    logic                    xfer;
    logic                    timeout_hit;

    rr_select #(
        .N (N_REQ)
    ) u_rr_select (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .idx   (sel_idx),
        .any   (sel_any)
    );

    // Mux out the granted requester's handshake and data. A compare loop is
    // used so grant_id never indexes past N_REQ-1.
    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_id == GRANT_ID_W'(i)) begin
                g_valid = req_valid[i];
                g_last  = req_last[i];
                g_data  = req_data[DATA_W*i +: DATA_W];
            end
        end
    end

`ifdef OUTPKT_ARB_TIMEOUT_EN
    logic [STALL_CNT_W-1:0] stall_cnt;

    // Only an empty granted requester counts as a stall; back-pressure from
    // full holds the count instead.
    assign timeout_hit = (state == XFER) && !g_valid &&
                         (stall_cnt == STALL_CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt <= '0;
        end else if (state != XFER || xfer || timeout_hit) begin
            stall_cnt <= '0;
        end else if (!g_valid) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err <= 1'b0;
        end else if (timeout_hit) begin
            err <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    // Next-state and the zero-latency write path: in XFER the granted word
    // goes straight to the FIFO whenever it is valid and there is room.
    always_comb begin
        state_next = state;
        xfer       = 1'b0;
        wr_en      = 1'b0;
        dout       = '0;
        req_rd_en  = '0;
        case (state)
            IDLE: begin
                if (sel_any) begin
                    state_next = XFER;
                end
            end
            XFER: begin
                xfer  = g_valid && !full;
                wr_en = xfer;
                if (xfer) begin
                    dout = g_data;
                end
                for (int i = 0; i < N_REQ; i++) begin
                    req_rd_en[i] = xfer && (grant_id == GRANT_ID_W'(i));
                end
                if ((xfer && g_last) || timeout_hit) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, grant and round-robin pointer. The pointer only moves when a
    // packet ends (or is truncated), so the finishing requester drops to
    // lowest priority for the next arbitration.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            rr_ptr    <= GRANT_ID_W'(N_REQ - 1);
            grant_id  <= '0;
            pkt_count <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && sel_any) begin
                grant_id <= sel_idx;
            end
            if (state == XFER && ((xfer && g_last) || timeout_hit)) begin
                rr_ptr <= grant_id;
            end
            if (state == XFER && xfer && g_last) begin
                pkt_count <= pkt_count + 1'b1;
            end
        end
    end

    assign busy = (state == XFER);

endmodule

// File: tb/tb_outpkt_arbiter.sv
// tb_outpkt_arbiter
// Self-checking bench for outpkt_arbiter. Requesters are FWFT queues owned by
// the bench; every word the DUT must write is pushed to a scoreboard as
// {grant_id, data} when it is loaded and popped when wr_en is seen.
// Timeout scenario is compiled when OUTPKT_ARB_TIMEOUT_EN is defined.
module tb_outpkt_arbiter;

    localparam int N = 4;

    logic                CLK = 1'b0;
    logic                RST = 1'b1;
    logic [N-1:0]        req_valid = '0;
    logic [16*N-1:0]     req_data  = '0;
    logic [N-1:0]        req_last  = '0;
    logic [N-1:0]        req_rd_en;
    logic [15:0]         dout;
    logic                wr_en;
    logic                full = 1'b0;
    logic [2:0]          grant_id;
    logic                busy;
    logic [15:0]         pkt_count;
    logic                err;

    int total = 0;
    int bad   = 0;

    logic [16:0]  src_q [N][$];
    logic [18:0]  exp_q [$];
    logic [18:0]  sb_exp;
    logic [N-1:0] sb_onehot;
    logic [N-1:0] en = '1;
    logic         samp_wr;
    logic [N-1:0] samp_rd;

    outpkt_arbiter #(
        .N_REQ          (N),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_rd_en (req_rd_en),
        .dout      (dout),
        .wr_en     (wr_en),
        .full      (full),
        .grant_id  (grant_id),
        .busy      (busy),
        .pkt_count (pkt_count),
        .err       (err)
    );

    always #5 CLK = ~CLK;

    // Scoreboard: compares every write against the expected order
    always @(negedge CLK) begin
        if (wr_en) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL sb_extra: wrote id=%0d data=%h, required no write", grant_id, dout);
            end else begin
                sb_exp = exp_q.pop_front();
                if ({grant_id, dout} !== sb_exp) begin
                    bad++;
                    $display("[TB] FAIL sb_word: got id=%0d data=%h, required id=%0d data=%h",
                             grant_id, dout, sb_exp[18:16], sb_exp[15:0]);
                end
            end
            sb_onehot = '0;
            sb_onehot[grant_id[1:0]] = 1'b1;
            total++;
            if (req_rd_en !== sb_onehot) begin
                bad++;
                $display("[TB] FAIL sb_rd_en: got %b, required %b", req_rd_en, sb_onehot);
            end
        end else begin
            total++;
            if (dout !== 16'h0 || req_rd_en !== '0) begin
                bad++;
                $display("[TB] FAIL idle_bus: dout=%h rd_en=%b, required 0000/0", dout, req_rd_en);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running, required finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic drive();
        logic [16:0] w;
        for (int i = 0; i < N; i++) begin
            if (en[i] && src_q[i].size() > 0) begin
                w = src_q[i][0];
                req_valid[i]         = 1'b1;
                req_data[16*i +: 16] = w[15:0];
                req_last[i]          = w[16];
            end else begin
                req_valid[i]         = 1'b0;
                req_data[16*i +: 16] = 16'h0;
                req_last[i]          = 1'b0;
            end
        end
    endtask

    // One clock: sample outputs on the falling edge, let the DUT commit on
    // the rising edge, then pop consumed words and present the next ones.
    task automatic step();
        @(negedge CLK);
        samp_wr = wr_en;
        samp_rd = req_rd_en;
        @(posedge CLK);
        #1;
        for (int i = 0; i < N; i++) begin
            if (samp_rd[i] && src_q[i].size() > 0) begin
                void'(src_q[i].pop_front());
            end
        end
        drive();
    endtask

    task automatic load_word(input int id, input logic [15:0] d, input logic last);
        src_q[id].push_back({last, d});
        exp_q.push_back({3'(id), d});
    endtask

    task automatic drain(output int left);
        int n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            step();
            n++;
        end
        left = exp_q.size();
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        drive();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge CLK);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy: got %b, required 0", busy); end
        total++; if (pkt_count !== 16'h0) begin bad++; $display("[TB] FAIL rst_pkt_count: got %h, required 0000", pkt_count); end
        total++; if (grant_id !== 3'd0) begin bad++; $display("[TB] FAIL rst_grant_id: got %0d, required 0", grant_id); end
        total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL rst_err: got %b, required 0", err); end
        total++; if (wr_en !== 1'b0) begin bad++; $display("[TB] FAIL rst_wr_en: got %b, required 0", wr_en); end
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_single_packet();
        logic [4:0] pat;
        load_word(0, 16'h1111, 1'b0);
        load_word(0, 16'h2222, 1'b0);
        load_word(0, 16'h3333, 1'b1);
        drive();
        for (int k = 0; k < 5; k++) begin
            step();
            pat[k] = samp_wr;
        end
        total++; if (pat !== 5'b01110) begin bad++; $display("[TB] FAIL single_wr_pattern: got %b, required 01110", pat); end
        total++; if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL single_drain: %0d words left, required 0", exp_q.size()); end
        total++; if (pkt_count !== 16'd1) begin bad++; $display("[TB] FAIL single_pkt_count: got %0d, required 1", pkt_count); end
        total++; if (grant_id !== 3'd0) begin bad++; $display("[TB] FAIL single_grant_id: got %0d, required 0", grant_id); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL single_busy: got %b, required 0", busy); end
    endtask

    task automatic test_round_robin();
        int left;
        do_reset();
        // Expected grant order 0,1,2,3,0 with two-word packets
        for (int w = 0; w < 2; w++) load_word(0, 16'h0A00 + 16'(w), w == 1);
        for (int i = 1; i < N; i++) begin
            for (int w = 0; w < 2; w++) load_word(i, 16'(i * 16'h1000) + 16'(w), w == 1);
        end
        for (int w = 0; w < 2; w++) load_word(0, 16'h0B00 + 16'(w), w == 1);
        drive();
        drain(left);
        total++; if (left != 0) begin bad++; $display("[TB] FAIL rr_drain: %0d words left, required 0", left); end
        total++; if (pkt_count !== 16'd5) begin bad++; $display("[TB] FAIL rr_pkt_count: got %0d, required 5", pkt_count); end
        total++; if (grant_id !== 3'd0) begin bad++; $display("[TB] FAIL rr_grant_id: got %0d, required 0", grant_id); end
    endtask

    task automatic test_full_stall();
        int left;
        for (int w = 0; w < 4; w++) load_word(2, 16'h2A00 + 16'(w), w == 3);
        drive();
        step();
        step();
        total++; if (samp_wr !== 1'b1) begin bad++; $display("[TB] FAIL full_first_word: wr_en=%b, required 1", samp_wr); end
        full = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            total++;
            if (samp_wr !== 1'b0 || samp_rd !== '0) begin
                bad++;
                $display("[TB] FAIL full_hold: wr_en=%b rd_en=%b, required 0/0", samp_wr, samp_rd);
            end
        end
        total++; if (busy !== 1'b1 || grant_id !== 3'd2) begin bad++; $display("[TB] FAIL full_grant: busy=%b id=%0d, required 1/2", busy, grant_id); end
        full = 1'b0;
        drain(left);
        total++; if (left != 0) begin bad++; $display("[TB] FAIL full_drain: %0d words left, required 0", left); end
        total++; if (pkt_count !== 16'd6) begin bad++; $display("[TB] FAIL full_pkt_count: got %0d, required 6", pkt_count); end
    endtask

    task automatic test_valid_drop();
        int left;
        do_reset();
        for (int w = 0; w < 3; w++) load_word(1, 16'h1C00 + 16'(w), w == 2);
        load_word(3, 16'h3C00, 1'b1);
        drive();
        step();
        step();
        en[1] = 1'b0;
        drive();
        for (int k = 0; k < 10; k++) begin
            step();
            total++;
            if (samp_wr !== 1'b0 || samp_rd !== '0 || grant_id !== 3'd1) begin
                bad++;
                $display("[TB] FAIL drop_hold: wr_en=%b rd_en=%b id=%0d, required 0/0/1", samp_wr, samp_rd, grant_id);
            end
        end
        en[1] = 1'b1;
        drive();
        drain(left);
        total++; if (left != 0) begin bad++; $display("[TB] FAIL drop_drain: %0d words left, required 0", left); end
        total++; if (pkt_count !== 16'd2) begin bad++; $display("[TB] FAIL drop_pkt_count: got %0d, required 2", pkt_count); end
        total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL drop_err: got %b, required 0", err); end
    endtask

    task automatic test_reset_mid_packet();
        int left;
        load_word(2, 16'h2D00, 1'b0);
        load_word(2, 16'h2D01, 1'b0);
        src_q[2].push_back({1'b0, 16'h2D02});
        src_q[2].push_back({1'b1, 16'h2D03});
        drive();
        step();
        step();
        step();
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL mid_busy_before: got %b, required 1", busy); end
        RST = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL mid_busy: got %b, required 0", busy); end
        total++; if (pkt_count !== 16'h0) begin bad++; $display("[TB] FAIL mid_pkt_count: got %0d, required 0", pkt_count); end
        total++; if (req_rd_en !== '0 || wr_en !== 1'b0) begin bad++; $display("[TB] FAIL mid_strobes: rd_en=%b wr_en=%b, required 0/0", req_rd_en, wr_en); end
        load_word(0, 16'h0D00, 1'b1);
        exp_q.push_back({3'd2, 16'h2D02});
        exp_q.push_back({3'd2, 16'h2D03});
        drive();
        @(negedge CLK);
        RST = 1'b0;
        drain(left);
        total++; if (left != 0) begin bad++; $display("[TB] FAIL mid_drain: %0d words left, required 0", left); end
        total++; if (pkt_count !== 16'd2) begin bad++; $display("[TB] FAIL mid_pkt_after: got %0d, required 2", pkt_count); end
    endtask

`ifdef OUTPKT_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int left;
        do_reset();
        load_word(1, 16'h1E00, 1'b0);
        src_q[1].push_back({1'b0, 16'h1E01});
        src_q[1].push_back({1'b1, 16'h1E02});
        load_word(2, 16'h2E00, 1'b1);
        drive();
        step();
        step();
        en[1] = 1'b0;
        drive();
        for (int k = 0; k < 15; k++) step();
        total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL to_early: err=%b after 15 stalls, required 0", err); end
        step();
        total++; if (err !== 1'b1 || busy !== 1'b0) begin bad++; $display("[TB] FAIL to_hit: err=%b busy=%b, required 1/0", err, busy); end
        drain(left);
        total++; if (left != 0) begin bad++; $display("[TB] FAIL to_drain: %0d words left, required 0", left); end
        total++; if (err !== 1'b1) begin bad++; $display("[TB] FAIL to_sticky: got %b, required 1", err); end
        src_q[1].delete();
        en[1] = 1'b1;
        do_reset();
        total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL to_clear: got %b, required 0", err); end
    endtask
`endif

    initial begin
        $display("[TB] outpkt_arbiter bench start");
        test_reset();
        test_single_packet();
        test_round_robin();
        test_full_stall();
        test_valid_drop();
        test_reset_mid_packet();
`ifdef OUTPKT_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
